// File: rtl/mem_pkg.sv
// Shared constants and types for the sensor-node scratch RAM.
package mem_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEPTH          = 1 << DEF_ADDR_WIDTH;

  typedef logic [DEF_DATA_WIDTH-1:0] word_t;
  typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/mem_read_port.sv
// Registered read port: word select mux feeding a data_out register that holds between reads.
module mem_read_port
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           read,
  input  logic [ADDR_WIDTH-1:0]                          addr,
  input  logic [(1<<ADDR_WIDTH)-1:0][DATA_WIDTH-1:0]     words,
  output logic [DATA_WIDTH-1:0]                          data_out
);

  logic [DATA_WIDTH-1:0] sel_word;

  assign sel_word = words[addr];

  // words is the pre-edge array, so a same-edge write to addr is not seen (read-first).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (read) begin
      data_out <= sel_word;
    end
  end

endmodule

// File: rtl/memory.sv
// Single-port RAM with strobed write/read, registered read data and asynchronous whole-array clear.
module memory
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int MEM_DEPTH = 1 << ADDR_WIDTH;

  // Flop array rather than block RAM: the asynchronous clear must reach every word.
  logic [MEM_DEPTH-1:0][DATA_WIDTH-1:0] mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (write) begin
      mem[addr] <= data_in;
    end
  end

  mem_read_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_read_port (
    .clk      (clk),
    .rst_n    (rst_n),
    .read     (read),
    .addr     (addr),
    .words    (mem),
    .data_out (data_out)
  );

endmodule

// File: tb/tb_memory.sv
// Bench for memory: directed strobes, expected read data queued by the driver and checked by a monitor.
module tb_memory;

  logic       clk;
  logic       rst_n;
  logic [3:0] addr;
  logic [7:0] data_in;
  logic       write;
  logic       read;
  logic [7:0] data_out;

  logic [7:0] exp_q[$];
  int         checks;
  int         errors;
  logic       rd_seen;

  memory dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .data_in  (data_in),
    .write    (write),
    .read     (read),
    .data_out (data_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobes are level-sampled: a read taken at an edge is checked at the following negedge.
  always @(posedge clk) rd_seen <= read && rst_n;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL read_unexpected: data_out=%02h with no expected value queued", data_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        checks++;
        if (data_out !== e) begin
          errors++;
          $display("FAIL read_data: got %02h expected %02h at %0t", data_out, e, $time);
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  // driver tasks; each is entered at a negedge and returns at the next negedge
  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    addr = a; data_in = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, input logic [7:0] e);
    addr = a; read = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic do_rw(input logic [3:0] a, input logic [7:0] d, input logic [7:0] e);
    addr = a; data_in = d; write = 1'b1; read = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    write = 1'b0; read = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; errors = 0; rd_seen = 1'b0;
    rst_n = 1'b0; addr = '0; data_in = '0; write = 1'b0; read = 1'b0;

    // reset clear
    @(negedge clk);
    check("reset_out", data_out, 8'h00);
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 16; i++) do_read(4'(i), 8'h00);

    // write/read sweep
    for (int i = 0; i < 16; i++) begin
      do_write(4'(i), 8'(2 * i));
      idle(1);
    end
    for (int i = 0; i < 16; i++) do_read(4'(i), 8'(2 * i));

    // hold with read low and a different address
    do_read(4'd5, 8'h0A);
    addr = 4'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold", data_out, 8'h0A);
    end

    // asynchronous reset mid-cycle, no clock edge involved
    #2 rst_n = 1'b0;
    #1 check("async_clear", data_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 16; i++) do_read(4'(i), 8'h00);

    // read-first collision
    do_write(4'd3, 8'h06);
    do_rw(4'd3, 8'hAA, 8'h06);
    do_read(4'd3, 8'hAA);

    // simultaneous write and read at different addresses
    do_write(4'd4, 8'h44);
    do_rw(4'd2, 8'h22, 8'h00);
    do_read(4'd2, 8'h22);

    // reset overrides an in-flight write; first edge after release processes strobes
    addr = 4'd7; data_in = 8'h55; write = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    write = 1'b0;
    rst_n = 1'b1;
    do_write(4'd8, 8'h77);
    do_read(4'd7, 8'h00);
    do_read(4'd8, 8'h77);
    do_read(4'd4, 8'h00);

    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d expected reads left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
